// File: rtl/bee_swarm_ctrl_pkg.sv
// Shared state encoding for the bee swarm controller and its per-slot FSMs.
package bee_swarm_ctrl_pkg;
  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] S_IDLE = 3'b001;
  localparam logic [STATE_W-1:0] S_MOVE = 3'b010;
  localparam logic [STATE_W-1:0] S_CAPT = 3'b100;
endpackage

// File: rtl/bee_swarm_ctrl_slot_fsm.sv
// One bee slot: IDLE/MOVE/CAPTURED state, respawn timer and first-capture pulse.
module bee_slot_fsm
  import bee_swarm_ctrl_pkg::*;
#(
  parameter int RESPAWN_FRAMES = 0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic tick_en_i,
  input  logic rel_i,
  input  logic capture_i,
  output logic load_bee_o,
  output logic moving_o,
  output logic captured_o,
  output logic caught_o,
  output logic cap_evt_o
);
  localparam int T_W = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;
  localparam logic [T_W-1:0] T_LAST = T_W'((RESPAWN_FRAMES > 0) ? RESPAWN_FRAMES - 1 : 0);

  logic [STATE_W-1:0] state_q, state_d;
  logic [T_W-1:0]     tmr_q, tmr_d;
  logic               caught_q;

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    cap_evt_o = 1'b0;
    case (state_q)
      S_IDLE: if (rel_i) state_d = S_MOVE;
      S_MOVE: if (capture_i) begin
        state_d   = S_CAPT;
        tmr_d     = '0;
        cap_evt_o = 1'b1;
      end
      S_CAPT: if (RESPAWN_FRAMES > 0 && tick_en_i) begin
        if (tmr_q == T_LAST) begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + T_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      tmr_q    <= '0;
      caught_q <= 1'b0;
    end else if (clear_i) begin
      state_q  <= S_IDLE;
      tmr_q    <= '0;
      caught_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      caught_q <= cap_evt_o;
    end
  end

  assign load_bee_o = (state_q == S_IDLE) || (state_q == S_CAPT);
  assign moving_o   = (state_q == S_MOVE);
  assign captured_o = (state_q == S_CAPT);
  assign caught_o   = caught_q;
endmodule

// File: rtl/bee_swarm_ctrl.sv
// Swarm controller: staggered release scheduler, per-bee slot FSMs and saturating capture score.
module bee_swarm_ctrl
  import bee_swarm_ctrl_pkg::*;
#(
  parameter int NUM_BEES       = 4,
  parameter int RELEASE_GAP    = 60,
  parameter int RESPAWN_FRAMES = 0,
  parameter int CNT_W          = 8
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                clear_i,
  input  logic                enable_i,
  input  logic                frame_tick_i,
  input  logic                can_capture_i,
  input  logic [NUM_BEES-1:0] overlap_i,
  output logic [NUM_BEES-1:0] load_bee_o,
  output logic [NUM_BEES-1:0] moving_o,
  output logic [NUM_BEES-1:0] captured_o,
  output logic [NUM_BEES-1:0] caught_o,
  output logic [CNT_W-1:0]    capture_count_o,
  output logic                all_captured_o
);
  localparam int GAP_W = (RELEASE_GAP > 1) ? $clog2(RELEASE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RELEASE_GAP - 1);
  localparam int SUM_W = CNT_W + 5;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  logic                tick_en, gap_wrap;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [NUM_BEES-1:0] rel, idle, cap_evt;
  logic [4:0]          pop;
  logic [SUM_W-1:0]    sum;
  logic                found;

  assign tick_en  = enable_i & frame_tick_i;
  assign gap_wrap = tick_en && (gap_q == GAP_LAST);
  assign gap_d    = !tick_en ? gap_q : (gap_wrap ? '0 : gap_q + GAP_W'(1));
  assign idle     = load_bee_o & ~captured_o;

  // Only the lowest-index IDLE slot is released; a wrap with no IDLE slot is simply lost.
  always_comb begin
    rel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_BEES; i++) begin
      if (!found && idle[i]) begin
        rel[i] = gap_wrap;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_BEES; i++) pop = pop + 5'(cap_evt[i]);
    sum     = SUM_W'(count_q) + SUM_W'(pop);
    count_d = (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      gap_q   <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      gap_q   <= '0;
      count_q <= '0;
    end else begin
      gap_q   <= gap_d;
      count_q <= count_d;
    end
  end

  for (genvar g = 0; g < NUM_BEES; g++) begin : g_slot
    bee_slot_fsm #(.RESPAWN_FRAMES(RESPAWN_FRAMES)) u_slot (
      .clk_i      (clk_i),
      .rst_n_i    (reset_n_i),
      .clear_i    (clear_i),
      .tick_en_i  (tick_en),
      .rel_i      (rel[g]),
      .capture_i  (overlap_i[g] & can_capture_i),
      .load_bee_o (load_bee_o[g]),
      .moving_o   (moving_o[g]),
      .captured_o (captured_o[g]),
      .caught_o   (caught_o[g]),
      .cap_evt_o  (cap_evt[g])
    );
  end

  assign capture_count_o = count_q;
  assign all_captured_o  = &captured_o;
endmodule

// File: tb/tb_bee_swarm_ctrl.sv
// Bench for bee_swarm_ctrl: two parameterisations driven together, checked against a behavioural model.
module tb_bee_swarm_ctrl;
  // bee status: 0 idle, 1 move, 2 captured
  typedef struct packed {
    logic [3:0][1:0] st;
    logic [3:0][7:0] tmr;
    logic [3:0]      caught;
    int              gap;
    int              score;
  } mdl_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0, en = 1'b0, tick = 1'b0, cap = 1'b0;
  logic [3:0] ov = '0;
  logic [3:0] a_load, a_mv, a_cp, a_ct, b_load, b_mv, b_cp, b_ct;
  logic [2:0] a_cnt;
  logic [1:0] b_cnt;
  logic       a_all, b_all;
  mdl_t       mA = '0, mB = '0;
  bit         chk_on = 1'b0;
  int         cmp_n = 0, err_n = 0;

  always #5 clk = ~clk;

  bee_swarm_ctrl #(.NUM_BEES(4), .RELEASE_GAP(2), .RESPAWN_FRAMES(3), .CNT_W(3)) u_a (
    .clk_i(clk), .reset_n_i(rst_n), .clear_i(clr), .enable_i(en), .frame_tick_i(tick),
    .can_capture_i(cap), .overlap_i(ov), .load_bee_o(a_load), .moving_o(a_mv),
    .captured_o(a_cp), .caught_o(a_ct), .capture_count_o(a_cnt), .all_captured_o(a_all));

  bee_swarm_ctrl #(.NUM_BEES(4), .RELEASE_GAP(3), .RESPAWN_FRAMES(0), .CNT_W(2)) u_b (
    .clk_i(clk), .reset_n_i(rst_n), .clear_i(clr), .enable_i(en), .frame_tick_i(tick),
    .can_capture_i(cap), .overlap_i(ov), .load_bee_o(b_load), .moving_o(b_mv),
    .captured_o(b_cp), .caught_o(b_ct), .capture_count_o(b_cnt), .all_captured_o(b_all));

  function automatic mdl_t step(mdl_t m, int gap_n, int resp_n, int cnt_w,
                                bit rs, bit e, bit t, bit c, logic [3:0] o);
    mdl_t n;
    int   rel, caps, lim;
    bit   tk;
    n = m;
    if (rs) begin
      n = '0;
      return n;
    end
    tk  = e && t;
    rel = -1;
    if (tk) begin
      if (m.gap + 1 == gap_n) begin
        n.gap = 0;
        for (int i = 3; i >= 0; i--) if (m.st[i] == 2'd0) rel = i;
      end else n.gap = m.gap + 1;
    end
    caps = 0;
    for (int i = 0; i < 4; i++) begin
      n.caught[i] = 1'b0;
      if (m.st[i] == 2'd0) begin
        if (i == rel) n.st[i] = 2'd1;
      end else if (m.st[i] == 2'd1) begin
        if (o[i] && c) begin
          n.st[i] = 2'd2; n.tmr[i] = '0; n.caught[i] = 1'b1; caps++;
        end
      end else if (resp_n > 0 && tk) begin
        if (int'(m.tmr[i]) + 1 == resp_n) n.st[i] = 2'd0;
        else n.tmr[i] = m.tmr[i] + 8'd1;
      end
    end
    lim = (1 << cnt_w) - 1;
    n.score = (m.score + caps > lim) ? lim : m.score + caps;
    return n;
  endfunction

  task automatic chk(string nm, int act, int exp);
    cmp_n++;
    if (act != exp) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(string tag, mdl_t m, logic [3:0] ld, logic [3:0] mv, logic [3:0] cp,
                         logic [3:0] ct, int cnt, logic all);
    logic [3:0] e_ld, e_mv, e_cp;
    for (int i = 0; i < 4; i++) begin
      e_mv[i] = (m.st[i] == 2'd1);
      e_cp[i] = (m.st[i] == 2'd2);
      e_ld[i] = !e_mv[i];
    end
    chk({tag, ".load_bee"}, ld, e_ld);
    chk({tag, ".moving"}, mv, e_mv);
    chk({tag, ".captured"}, cp, e_cp);
    chk({tag, ".caught"}, ct, m.caught);
    chk({tag, ".count"}, cnt, m.score);
    chk({tag, ".all_captured"}, all, &e_cp);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp_dut("A", mA, a_load, a_mv, a_cp, a_ct, a_cnt, a_all);
      cmp_dut("B", mB, b_load, b_mv, b_cp, b_ct, b_cnt, b_all);
    end
  end

  task automatic cyc(bit c, bit e, bit t, bit cp_, logic [3:0] o);
    mdl_t na, nb;
    clr = c; en = e; tick = t; cap = cp_; ov = o;
    na = step(mA, 2, 3, 3, c || !rst_n, e, t, cp_, o);
    nb = step(mB, 3, 0, 2, c || !rst_n, e, t, cp_, o);
    @(posedge clk);
    #1;
    mA = na;
    mB = nb;
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    #1 rst_n = 1'b1;
    chk_on = 1'b1;
    chk("reset.load_bee", a_load, 4'hF);
    chk("reset.count", a_cnt, 0);

    // staggered release: A every 2nd tick, B every 3rd tick
    cyc(1, 0, 0, 0, 0);
    for (int t = 1; t <= 10; t++) begin
      repeat (9) cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 1, 0, 0);
      case (t)
        2: chk("rel.tick2", a_mv, 4'b0001);
        4: chk("rel.tick4", a_mv, 4'b0011);
        6: chk("rel.tick6", a_mv, 4'b0111);
        8: begin chk("rel.tick8", a_mv, 4'b1111); chk("relB.tick8", b_mv, 4'b0011); end
        9: chk("relB.tick9", b_mv, 4'b0111);
        10: chk("rel.tick10_drop", a_mv, 4'b1111);
        default: ;
      endcase
    end

    cyc(0, 1, 0, 0, 4'hF);
    chk("nocap.moving", a_mv, 4'hF);
    chk("nocap.count", a_cnt, 0);
    cyc(0, 1, 0, 1, 4'b1010);
    chk("cap2.caught", a_ct, 4'b1010);
    chk("cap2.count", a_cnt, 2);
    chk("cap2B.count", b_cnt, 1);
    cyc(0, 1, 0, 0, 4'b0000);
    chk("cap2.caught_off", a_ct, 4'b0000);
    cyc(0, 1, 0, 1, 4'b0101);
    chk("cap4.all", a_all, 1);
    chk("cap4.count", a_cnt, 4);
    chk("cap4B.count", b_cnt, 3);

    repeat (5) cyc(0, 0, 1, 0, 0);
    chk("freeze.captured", a_cp, 4'hF);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    chk("resp2.captured", a_cp, 4'hF);
    cyc(0, 1, 1, 0, 0);
    chk("resp3.captured", a_cp, 4'h0);
    chk("resp3.load_bee", a_load, 4'hF);
    chk("resp3B.moving", b_mv, 4'b1000);
    cyc(0, 1, 0, 1, 4'b1000);
    chk("satB.count", b_cnt, 3);
    chk("satB.all", b_all, 1);
    cyc(1, 1, 0, 0, 0);
    chk("clear.count", a_cnt, 0);
    chk("clearB.load_bee", b_load, 4'hF);

    for (int k = 0; k < 4000; k++) begin
      cyc(($urandom % 400) == 0, ($urandom % 8) != 0, ($urandom % 3) == 0,
          ($urandom % 2) == 1, 4'($urandom));
      if (k == 2000) begin
        #1 rst_n = 1'b0;
        #1;
        chk("async.load_bee", a_load, 4'hF);
        chk("async.moving", a_mv, 4'h0);
        chk("async.count", a_cnt, 0);
        chk("asyncB.count", b_cnt, 0);
        mA = '0;
        mB = '0;
        cyc(0, 1, 1, 1, 4'hF);
        cyc(0, 1, 1, 1, 4'hF);
        #1 rst_n = 1'b1;
      end
    end

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
